// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Read-side controller for a standard-mode (non-FWFT) synchronous
//            FIFO. Waits for an almost-full rising edge or a fill-level
//            trigger, idles for a settle interval, then drains the FIFO in
//            bursts without underflowing. Delivered words are checked against
//            an incrementing pattern and discontinuities are counted.
// Ports    : sys_clk, sys_rst_n    - clock, async active-low reset
//            rd_enable             - soft enable, low forces IDLE
//            almost_full, fifo_empty, fifo_rd_cnt, fifo_rdata - FIFO read side
//            fifo_rd_en            - FIFO read strobe (combinational)
//            rd_data, rd_data_vld  - registered read word and its strobe
//            burst_done            - one-cycle pulse per completed burst
//            busy                  - controller not in IDLE
//            err_cnt, err_flag     - saturating mismatch count, sticky flag
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_W        = 8,
    parameter int CNT_W         = 9,
    parameter int START_LEVEL   = 200,
    parameter int SETTLE_CYCLES = 10,
    parameter int BURST_LEN     = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rd_enable,
    input  logic              almost_full,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_rd_cnt,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              burst_done,
    output logic              busy,
    output logic [15:0]       err_cnt,
    output logic              err_flag
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_read   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    // Word counter only needs to reach BURST_LEN; with unlimited bursts it is
    // kept at one bit and its value is never consulted.
    localparam int WC_W = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;

    localparam logic [7:0]      c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W:0]  c_start_level = (CNT_W + 1)'(START_LEVEL);
    localparam logic [WC_W-1:0] c_burst_len   = WC_W'(BURST_LEN);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_af_d;
    logic [7:0]        r_settle_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic              r_rd_en_d;
    logic [DATA_W-1:0] r_exp_data;

    logic              w_af_rise;
    logic              w_level_hit;
    logic              w_cnt_ok;
    logic [WC_W-1:0]   w_word_next;
    logic              w_burst_hit;

    // ------------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------------
    assign w_af_rise   = almost_full & ~r_af_d;
    // Extra MSB keeps the compare valid when START_LEVEL uses the full count range.
    assign w_level_hit = (START_LEVEL != 0) && ({1'b0, fifo_rd_cnt} >= c_start_level);

    // ------------------------------------------------------------------------
    // Burst accounting
    // ------------------------------------------------------------------------
    assign w_cnt_ok    = (BURST_LEN == 0) || (r_word_cnt < c_burst_len);
    assign fifo_rd_en  = (r_state == c_st_read) & rd_enable & ~fifo_empty & w_cnt_ok;
    // Look ahead by the current strobe so DONE follows the last strobe directly.
    assign w_word_next = r_word_cnt + WC_W'(fifo_rd_en);
    assign w_burst_hit = (BURST_LEN != 0) && (w_word_next == c_burst_len);

    assign busy        = (r_state != c_st_idle);
    assign burst_done  = (r_state == c_st_done) & rd_enable;

    // ------------------------------------------------------------------------
    // Next-state logic; a dropped enable overrides every transition.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_af_rise || w_level_hit) begin
                    w_state_nxt = c_st_settle;
                end
            end
            c_st_settle: begin
                if (r_settle_cnt == c_settle_last) begin
                    w_state_nxt = c_st_read;
                end
            end
            c_st_read: begin
                if (fifo_empty || w_burst_hit) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (!rd_enable) begin
            w_state_nxt = c_st_idle;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers. Counters are held at zero outside their state, so
    // they always start from zero on entry.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= c_st_idle;
            r_af_d       <= 1'b0;
            r_settle_cnt <= 8'd0;
            r_word_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_af_d  <= almost_full;

            if (r_state == c_st_settle) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end else begin
                r_settle_cnt <= 8'd0;
            end

            if (r_state != c_st_read) begin
                r_word_cnt <= '0;
            end else if (fifo_rd_en) begin
                r_word_cnt <= w_word_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data path and pattern checker. The FIFO presents data one cycle after
    // the strobe; the word is captured and checked on that cycle's edge.
    // The checker always reloads from the received word so a single jump in
    // the sequence counts as one error.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_en_d   <= 1'b0;
            rd_data_vld <= 1'b0;
            rd_data     <= '0;
            r_exp_data  <= '0;
            err_cnt     <= 16'd0;
            err_flag    <= 1'b0;
        end else begin
            r_rd_en_d   <= fifo_rd_en;
            rd_data_vld <= r_rd_en_d;
            if (r_rd_en_d) begin
                rd_data    <= fifo_rdata;
                r_exp_data <= fifo_rdata + DATA_W'(1);
                if (fifo_rdata != r_exp_data) begin
                    err_flag <= 1'b1;
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Self-checking bench. Two readers share one behavioural FIFO:
//            a burst reader (BURST_LEN=16, START_LEVEL=32, SETTLE=4) and a
//            drain reader (BURST_LEN=0, level trigger off, SETTLE=10). Only
//            the selected reader is enabled at a time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       sel;            // 0: burst reader, 1: drain reader
    logic       rd_enable_b;
    logic       rd_enable_d;
    logic       af_force;
    logic       wr_req;
    logic [7:0] wr_data;

    always #5 sys_clk = ~sys_clk;

    // Behavioural standard-mode FIFO
    logic [7:0] fq[$];
    int         fcnt = 0;
    logic [7:0] fifo_rdata = 8'd0;
    logic       almost_full;
    logic       fifo_empty;
    logic [8:0] fifo_rd_cnt;
    logic       rd_en_m;

    assign almost_full = af_force | (fcnt >= 250);
    assign fifo_empty  = (fcnt == 0);
    assign fifo_rd_cnt = 9'(fcnt);

    always @(posedge sys_clk) begin
        if (rd_en_m && fcnt != 0) fifo_rdata <= fq.pop_front();
        if (wr_req) fq.push_back(wr_data);
        fcnt <= fcnt + (wr_req ? 1 : 0) - ((rd_en_m && fcnt != 0) ? 1 : 0);
    end

    // DUT outputs
    logic        b_rd_en, b_vld, b_done, b_busy, b_flag;
    logic [7:0]  b_rd_data;
    logic [15:0] b_err;
    logic        d_rd_en, d_vld, d_done, d_busy, d_flag;
    logic [7:0]  d_rd_data;
    logic [15:0] d_err;

    fifo_burst_reader #(
        .DATA_W(8), .CNT_W(9), .START_LEVEL(32), .SETTLE_CYCLES(4), .BURST_LEN(16)
    ) u_dut_burst (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rd_enable(rd_enable_b),
        .almost_full(almost_full), .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(b_rd_en), .rd_data(b_rd_data),
        .rd_data_vld(b_vld), .burst_done(b_done), .busy(b_busy),
        .err_cnt(b_err), .err_flag(b_flag)
    );

    fifo_burst_reader #(
        .DATA_W(8), .CNT_W(9), .START_LEVEL(0), .SETTLE_CYCLES(10), .BURST_LEN(0)
    ) u_dut_drain (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rd_enable(rd_enable_d),
        .almost_full(almost_full), .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(d_rd_en), .rd_data(d_rd_data),
        .rd_data_vld(d_vld), .burst_done(d_done), .busy(d_busy),
        .err_cnt(d_err), .err_flag(d_flag)
    );

    logic        vld_m, done_m, busy_m, flag_m;
    logic [7:0]  rd_data_m;
    logic [15:0] err_m;
    assign rd_en_m   = sel ? d_rd_en   : b_rd_en;
    assign vld_m     = sel ? d_vld     : b_vld;
    assign done_m    = sel ? d_done    : b_done;
    assign busy_m    = sel ? d_busy    : b_busy;
    assign flag_m    = sel ? d_flag    : b_flag;
    assign rd_data_m = sel ? d_rd_data : b_rd_data;
    assign err_m     = sel ? d_err     : b_err;

    // Monitor: event counters and cycle stamps, sampled mid-cycle
    int         cyc = 0, af_rise_cyc = 0, rd_start_cyc = 0, last_vld_cyc = 0, last_done_cyc = 0;
    int         vld_cnt = 0, done_cnt = 0, empty_viol = 0;
    logic       af_prev = 1'b0, rd_en_prev = 1'b0;
    logic [7:0] delivered[$];
    logic [7:0] written[$];

    always @(negedge sys_clk) begin
        cyc        <= cyc + 1;
        af_prev    <= almost_full;
        rd_en_prev <= rd_en_m;
        if (almost_full && !af_prev) af_rise_cyc <= cyc;
        if (rd_en_m && !rd_en_prev) rd_start_cyc <= cyc;
        if ((b_rd_en || d_rd_en) && fifo_empty) empty_viol <= empty_viol + 1;
        if (vld_m) begin
            vld_cnt      <= vld_cnt + 1;
            last_vld_cyc <= cyc;
            delivered.push_back(rd_data_m);
        end
        if (done_m) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic write_words(input int start, input int n);
        for (int j = 0; j < n; j++) begin
            tick();
            wr_req  = 1'b1;
            wr_data = 8'(start + j);
            written.push_back(8'(start + j));
        end
        tick();
        wr_req = 1'b0;
    endtask

    typedef struct packed {
        int sel;       // reader under test
        int s1, n1;    // first write segment
        int s2, n2;    // second write segment
        int force_af;  // pulse almost_full after writing
        int vld;       // expected rd_data_vld pulses
        int done;      // expected burst_done pulses
        int err;       // expected err_cnt afterwards
        int flag;      // expected err_flag afterwards
        int cnt;       // expected FIFO fill afterwards
        int lat;       // af_rise cycle to first strobe, -1 = not checked
        int done_off;  // first strobe to burst_done cycle
    } vec_t;

    vec_t tbl[7];
    int   v0, d0, k0, e0, mism;
    bit   ok;

    initial begin
        tbl[0] = '{1,  0, 256,  0,  0, 0, 256, 1, 0, 0,  0, 11, 257};
        tbl[1] = '{0,  0,  40,  0,  0, 0,  16, 1, 0, 0, 24, -1,  16};
        tbl[2] = '{0, 40,   8,  0,  0, 0,  16, 1, 0, 0, 16, -1,  16};
        tbl[3] = '{0,  0,   0,  0,  0, 1,  16, 1, 0, 0,  0,  5,  16};
        tbl[4] = '{1,  0,  10, 20, 10, 1,  20, 1, 1, 1,  0, 11,  21};
        tbl[5] = '{0, 48,   5,  0,  0, 1,   5, 1, 0, 0,  0,  5,   6};
        tbl[6] = '{1, 30, 236,  0,  0, 1, 236, 1, 1, 1,  0, 11, 237};

        sys_rst_n   = 1'b0;
        sel         = 1'b0;
        rd_enable_b = 1'b0;
        rd_enable_d = 1'b0;
        af_force    = 1'b0;
        wr_req      = 1'b0;
        wr_data     = 8'd0;

        // Reset state
        repeat (2) sample();
        check("rst_rd_en",    {31'd0, b_rd_en}, 32'd0);
        check("rst_rd_data",  {24'd0, b_rd_data}, 32'd0);
        check("rst_vld",      {31'd0, b_vld}, 32'd0);
        check("rst_done",     {31'd0, b_done}, 32'd0);
        check("rst_busy",     {31'd0, b_busy | d_busy}, 32'd0);
        check("rst_err_cnt",  {16'd0, b_err | d_err}, 32'd0);
        check("rst_err_flag", {31'd0, b_flag | d_flag}, 32'd0);
        tick();
        sys_rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            tick();
            sel         = (tbl[i].sel != 0);
            rd_enable_b = (tbl[i].sel == 0);
            rd_enable_d = (tbl[i].sel != 0);
            v0 = vld_cnt; d0 = done_cnt; k0 = delivered.size(); e0 = empty_viol;
            write_words(tbl[i].s1, tbl[i].n1);
            write_words(tbl[i].s2, tbl[i].n2);
            if (tbl[i].force_af != 0) begin
                tick();
                af_force = 1'b1;
                tick();
                af_force = 1'b0;
            end
            ok = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                sample();
                if ((done_cnt - d0) >= tbl[i].done && !busy_m) begin
                    ok = 1'b1;
                    break;
                end
            end
            check($sformatf("e%0d_finish", i), {31'd0, ok}, 32'd1);
            repeat (8) sample();
            check($sformatf("e%0d_vld_cnt", i), vld_cnt - v0, tbl[i].vld);
            check($sformatf("e%0d_done_cnt", i), done_cnt - d0, tbl[i].done);
            check($sformatf("e%0d_err_cnt", i), {16'd0, err_m}, tbl[i].err);
            check($sformatf("e%0d_err_flag", i), {31'd0, flag_m}, tbl[i].flag);
            check($sformatf("e%0d_fifo_cnt", i), fcnt, tbl[i].cnt);
            check($sformatf("e%0d_busy", i), {31'd0, busy_m}, 32'd0);
            check($sformatf("e%0d_done_off", i), last_done_cyc - rd_start_cyc, tbl[i].done_off);
            check($sformatf("e%0d_vld_off", i), last_vld_cyc - rd_start_cyc, tbl[i].vld + 1);
            if (tbl[i].lat >= 0)
                check($sformatf("e%0d_latency", i), rd_start_cyc - af_rise_cyc, tbl[i].lat);
            mism = 0;
            for (int k = k0; k < delivered.size(); k++)
                if (delivered[k] !== written[k]) mism++;
            check($sformatf("e%0d_data_order", i), mism, 0);
            check($sformatf("e%0d_rd_while_empty", i), empty_viol - e0, 0);
        end

        // Enable dropped on the third read cycle of a level-triggered burst
        tick();
        sel         = 1'b0;
        rd_enable_d = 1'b0;
        rd_enable_b = 1'b0;
        write_words(53, 40);
        v0 = vld_cnt; d0 = done_cnt;
        tick();
        rd_enable_b = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            sample();
            if (rd_en_m) begin
                ok = 1'b1;
                break;
            end
        end
        check("drop_first_strobe", {31'd0, ok}, 32'd1);
        tick();
        tick();
        rd_enable_b = 1'b0;
        sample();
        check("drop_rd_en_same_cycle", {31'd0, b_rd_en}, 32'd0);
        check("drop_busy_same_cycle", {31'd0, b_busy}, 32'd1);
        sample();
        check("drop_idle_next", {31'd0, b_busy}, 32'd0);
        repeat (4) sample();
        check("drop_vld_cnt", vld_cnt - v0, 32'd2);
        check("drop_no_done", done_cnt - d0, 32'd0);
        check("drop_fifo_cnt", fcnt, 32'd38);
        check("drop_rd_data", {24'd0, b_rd_data}, 32'd54);
        check("drop_err_cnt", {16'd0, b_err}, 32'd0);

        // Asynchronous reset in the middle of SETTLE
        tick();
        rd_enable_b = 1'b1;
        tick();
        tick();
        sample();
        check("settle_busy", {31'd0, b_busy}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("arst_busy",     {31'd0, b_busy}, 32'd0);
        check("arst_rd_en",    {31'd0, b_rd_en}, 32'd0);
        check("arst_rd_data",  {24'd0, b_rd_data}, 32'd0);
        check("arst_vld",      {31'd0, b_vld}, 32'd0);
        check("arst_done",     {31'd0, b_done}, 32'd0);
        check("arst_err_cnt",  {16'd0, d_err}, 32'd0);
        check("arst_err_flag", {31'd0, d_flag}, 32'd0);
        check("arst_drain_rd_data", {24'd0, d_rd_data}, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
